// File: rtl/enc_pkg.sv
// Shared definitions for the encoder/decoder family: default width,
// result-slot state encoding and a multi-hot detector.
package enc_pkg;

  localparam int DEFAULT_N = 4;
  localparam int MAX_N     = 64;

  // Result-slot state; out_valid is simply (state == ST_FULL).
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // True when more than one bit is set (popcount > 1); callers zero-extend to MAX_N.
  function automatic logic multi_hot(input logic [MAX_N-1:0] v);
    return (v & (v - MAX_N'(1))) != '0;
  endfunction

endpackage

// File: rtl/rr_priority_encoder_if.sv
// Request/result port bundle for rr_priority_encoder.
// Handshake: a result transfers on a clk edge where out_valid && out_ready;
// out_valid, out_idx and out_multi stay stable while out_valid && !out_ready.
interface rr_priority_encoder_if #(
  parameter int N = enc_pkg::DEFAULT_N
);
  localparam int W = $clog2(N);

  logic         enable;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         out_multi;

  // Encoder side.
  modport master (
    input  enable, req, out_ready,
    output out_valid, out_idx, out_multi
  );

  // Request source / result consumer side.
  modport slave (
    output enable, req, out_ready,
    input  out_valid, out_idx, out_multi
  );
endinterface

// File: rtl/rr_priority_encoder_pick.sv
// Round-robin pick: first set req bit at or after ptr, wrapping modulo N.
// Purely combinational: rotate down by ptr, find first set, add ptr back.
module rr_pick
  import enc_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] sel,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    // Descending scan so the lowest set bit wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
    // N is a power of two, so W-bit addition wraps modulo N.
    sel = off + ptr;
    any = |req;
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered round-robin priority encoder with a valid/ready result port.
// Holds the priority pointer, the one-entry result slot and its handshake.
module rr_priority_encoder
  import enc_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int W = $clog2(N)
) (
  input  logic                        clk,
  input  logic                        rst,
  rr_priority_encoder_if.master       bus,
  output state_t                      dbg_state
);

  state_t       state, next_state;
  logic [W-1:0] ptr;
  logic [W-1:0] idx_q;
  logic         multi_q;
  logic [W-1:0] sel;
  logic         any;
  logic         slot_free;
  logic         capture;

  rr_pick #(.N(N)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .sel (sel),
    .any (any)
  );

  always_comb begin
    slot_free  = (state == ST_EMPTY) || bus.out_ready;
    capture    = bus.enable && any && slot_free;
    next_state = state;
    case (state)
      ST_EMPTY: if (capture) next_state = ST_FULL;
      ST_FULL:  if (bus.out_ready && !capture) next_state = ST_EMPTY;
      default:  next_state = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_EMPTY;
      ptr     <= '0;
      idx_q   <= '0;
      multi_q <= 1'b0;
    end else begin
      state <= next_state;
      // Pointer moves only on capture, never on accept.
      if (capture) begin
        idx_q   <= sel;
        multi_q <= multi_hot(MAX_N'(bus.req));
        ptr     <= sel + W'(1);
      end
    end
  end

  assign bus.out_valid = (state == ST_FULL);
  assign bus.out_idx   = idx_q;
  assign bus.out_multi = multi_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder (N=4) with hand-computed expectations.
module tb_rr_priority_encoder;
  import enc_pkg::*;

  localparam int N = 4;
  localparam int W = $clog2(N);

  logic   clk;
  logic   rst;
  state_t dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];

  rr_priority_encoder_if #(.N(N)) bus ();

  rr_priority_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [N-1:0] r, input logic rdy);
    bus.enable    = en;
    bus.req       = r;
    bus.out_ready = rdy;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [W-1:0] idx,
                           input logic m);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".idx"},   32'(bus.out_idx),   32'(idx));
    check({tag, ".multi"}, 32'(bus.out_multi), 32'(m));
  endtask

  initial begin
    // Reset held two cycles with everything else active.
    rst = 1'b1;
    drive(1'b1, 4'b1111, 1'b1);
    tick();
    check_out("reset_c1", 1'b0, 2'd0, 1'b0);
    check("reset_c1.state", 32'(dbg_state), 32'(ST_EMPTY));
    tick();
    check_out("reset_c2", 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    // Single line
    drive(1'b1, 4'b0100, 1'b1);
    tick();
    check_out("single", 1'b1, 2'd2, 1'b0);
    check("single.state", 32'(dbg_state), 32'(ST_FULL));
    drive(1'b1, 4'b0000, 1'b1);
    tick();
    check_out("single_drain", 1'b0, 2'd2, 1'b0);

    // Fresh pointer for the round-robin sequence.
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Round-robin with wrap from 3 to 0
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    drive(1'b1, 4'b1111, 1'b1);
    while (exp_q.size() > 0) begin
      tick();
      check_out("rr", 1'b1, exp_q.pop_front(), 1'b1);
    end
    // ptr is now 2

    drive(1'b1, 4'b0000, 1'b1);
    tick();
    check("rr_drain.valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: ptr=2, req=0011 -> scan 2,3,0 picks 0
    drive(1'b1, 4'b0011, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("bp_hold", 1'b1, 2'd0, 1'b1);
    end
    bus.out_ready = 1'b1;
    tick();
    check_out("bp_accept_capture", 1'b1, 2'd1, 1'b1);
    drive(1'b1, 4'b0000, 1'b1);
    tick();
    check_out("bp_drain", 1'b0, 2'd1, 1'b1);

    // Enable gating
    drive(1'b0, 4'b1000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("en_gate.valid", 32'(bus.out_valid), 32'd0);
    end
    bus.enable = 1'b1;
    tick();
    check_out("en_raise", 1'b1, 2'd3, 1'b0);
    // ptr wrapped to 0

    // Held result drains with enable low.
    drive(1'b0, 4'b1111, 1'b1);
    tick();
    check_out("en_low_drain", 1'b0, 2'd3, 1'b0);

    // Reset mid-operation with a pending result.
    drive(1'b1, 4'b0100, 1'b1);
    tick();
    check_out("mid_capture", 1'b1, 2'd2, 1'b0);
    drive(1'b1, 4'b0001, 1'b0);
    tick();
    check_out("mid_hold", 1'b1, 2'd2, 1'b0);
    rst = 1'b1;
    tick();
    check_out("mid_reset", 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 4'b1010, 1'b1);
    tick();
    check_out("post_reset_ptr0", 1'b1, 2'd1, 1'b1);
    // ptr=2 now: 1010 scanning 2,3 picks 3
    tick();
    check_out("post_reset_next", 1'b1, 2'd3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
